dbus_arbiter: RTL and testbench
===============================

Name: dbus_arbiter

Overview:
- Two-master arbiter for the shared 16-bit data bus, which carries one address, write data, byte write enables, and read data with 1-cycle latency.
- Lets a DMA/peripheral master (port 1) share memory and IO with the CPU data port (port 0).
- Sits between the masters and the system address decoder.
- Uses round-robin arbitration with an optional bounded bus lock, and routes registered read responses back to the owning master.

Parameters:
- AW, 16: address width.
- DW, 16: data width; byte enables are DW/8 bits.
- MAXHOLD, 4: maximum consecutive locked grants to one master while the other is requesting; must be ≥1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req0, req1  in  1  access request from master 0 / master 1.
- lock0, lock1  in  1  requests that the grant be held for the next cycle (burst).
- addr0, addr1  in  AW  access address.
- wen0, wen1  in  DW/8  byte write enables; all-zero means read.
- wdata0, wdata1  in  DW  write data.
- gnt0, gnt1  out  1  grant; the access is performed in every cycle where gnt=1.
- rdata0, rdata1  out  DW  read data, valid only when the matching rvalid=1, else 0.
- rvalid0, rvalid1  out  1  read response valid, exactly one cycle after a granted read.
- bus_addr  out  AW  shared address; drives both the read and write address.
- bus_wen  out  DW/8  shared byte write enables.
- bus_wdata  out  DW  shared write data.
- bus_rdata  in  DW  shared read data; corresponds to the address presented in the previous cycle.

Behaviour:
- Reset asserted (reset=0):
  - gnt0/1=0, rvalid0/1=0, rdata0/1=0.
  - bus_addr/bus_wen/bus_wdata=0.
  - last_owner=1, so master 0 wins the first tie.
  - hold_cnt=0, locked=0.
  - Reset mid-operation discards any pending read response; no rvalid follows release of reset.
- State: last_owner (1b), locked (1b), hold_cnt (clog2(MAXHOLD+1) bits). All are registered.
- Grant is combinational from req and state, and always one-hot or zero:
  - Only one master requesting: that master is granted.
  - Both requesting, locked=1, and hold_cnt<MAXHOLD: last_owner is granted.
  - Both requesting otherwise: the master ≠ last_owner is granted (round-robin).
  - No requests: no grant, bus_wen=0, bus_addr/bus_wdata hold 0.
- Bus mux: bus_addr/bus_wen/bus_wdata carry the granted master's addr/wen/wdata.
- A grant is never issued without req in the same cycle.
- State update on each clock edge with a grant to master g:
  - last_owner←g.
  - locked←lock_g.
  - hold_cnt←(g==last_owner && locked) ? sat(hold_cnt+1) : 1.
  - hold_cnt saturates at MAXHOLD.
- State update on a cycle with no grant: locked←0, hold_cnt←0; last_owner unchanged.
- Lock bound:
  - With the other master requesting, a locked owner gets at most MAXHOLD consecutive grants.
  - After that the other master is granted for one cycle. Its lock may then retain the bus.
  - If the other master is idle, the lock is unbounded and hold_cnt saturates.
- Read response:
  - rvalid_g←gnt_g && wen_g==0, registered.
  - rdata_g = rvalid_g ? bus_rdata : 0.
  - Back-to-back reads from alternating masters return in grant order, one per cycle.
- Writes: no response; complete in the granted cycle.
- Simultaneous events:
  - A read response for one master and a new grant to the other may occur in the same cycle. This is legal.
  - Lock asserted without req is ignored.

Decomposition:
- Package dbus_pkg:
  - AW/DW defaults.
  - typedef owner_t (enum OWN0, OWN1).
  - typedef dbus_req_t struct {addr, wen, wdata}.
  - Function is_read(wen).
- One sub-module: dbus_grant_logic, covering the combinational grant plus the last_owner/locked/hold_cnt registers.
- The top level holds the bus mux and the read-response pipeline.

Test Plan:
- Reset release, then req0=1 (read, addr 0x2000) → gnt0=1 the same cycle, bus_addr=0x2000, bus_wen=0. Next cycle rvalid0=1, rdata0=bus_rdata (0xBEEF), rvalid1=0.
- req0 and req1 both held 1 with lock=0 for 4 cycles → grants alternate 0,1,0,1, starting with master 0 after reset.
- Master 1 writes wen1=2'b10, wdata1=0xAB00, addr1=0x0004 while req0=0 → bus_wen=2'b10, bus_wdata=0xAB00. rvalid1 never asserts.
- Both requesting, master 0 holds lock0=1, MAXHOLD=4 → gnt0 for 4 consecutive cycles, then gnt1 for 1 cycle, then gnt0 again.
- Lock with the other master idle: lock1=1, req1=1 for 10 cycles → gnt1 held for all 10 cycles, and hold_cnt saturates at 4.
- Reset pulled low the cycle after a granted read by master 1 → rvalid1=0 immediately and stays 0 after release. All bus outputs are 0 during reset.

Source files
------------

// File: rtl/dbus_pkg.sv
// Shared types and helpers for the two-master data-bus arbiter.
// Widths here are the default bus geometry used by the top level.
package dbus_pkg;
   localparam int DBUS_AW = 16;
   localparam int DBUS_DW = 16;
   localparam int DBUS_BW = DBUS_DW / 8;

   typedef enum logic {
      OWN0 = 1'b0,
      OWN1 = 1'b1
   } owner_t;

   typedef struct packed {
      logic [DBUS_AW-1:0] addr;
      logic [DBUS_BW-1:0] wen;
      logic [DBUS_DW-1:0] wdata;
   } dbus_req_t;

   function automatic logic is_read(input logic [DBUS_BW-1:0] wen);
      return (wen == '0);
   endfunction
endpackage

// File: rtl/dbus_grant_logic.sv
// Round-robin grant with a bounded bus lock; owns last_owner/locked/hold_cnt.
// Grants are combinational from the requests and are forced low while in reset.
module dbus_grant_logic
   import dbus_pkg::*;
#(
   parameter int MAXHOLD = 4
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_req0,
   input  logic i_req1,
   input  logic i_lock0,
   input  logic i_lock1,
   output logic o_gnt0,
   output logic o_gnt1
);
   localparam int HW = $clog2(MAXHOLD + 1);
   localparam logic [HW-1:0] HOLD_MAX = HW'(MAXHOLD);

   owner_t          r_last_owner;
   logic            r_locked;
   logic [HW-1:0]   r_hold_cnt;

   logic            w_keep;
   logic            w_pick0;
   logic            w_pick1;
   logic            w_gnt0;
   logic            w_gnt1;
   owner_t          w_owner;

   always_comb begin
      w_keep  = r_locked && (r_hold_cnt < HOLD_MAX);
      w_pick0 = 1'b0;
      w_pick1 = 1'b0;
      if (i_req0 && i_req1) begin
         // Contention: a live lock keeps the previous owner, else alternate.
         if (w_keep) begin
            w_pick0 = (r_last_owner == OWN0);
            w_pick1 = (r_last_owner == OWN1);
         end else begin
            w_pick0 = (r_last_owner == OWN1);
            w_pick1 = (r_last_owner == OWN0);
         end
      end else begin
         w_pick0 = i_req0;
         w_pick1 = i_req1;
      end
      w_gnt0  = w_pick0 & i_rst_n;
      w_gnt1  = w_pick1 & i_rst_n;
      w_owner = w_gnt1 ? OWN1 : OWN0;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_last_owner <= OWN1;
         r_locked     <= 1'b0;
         r_hold_cnt   <= '0;
      end else if (w_gnt0 || w_gnt1) begin
         r_last_owner <= w_owner;
         r_locked     <= w_gnt1 ? i_lock1 : i_lock0;
         if ((w_owner == r_last_owner) && r_locked) begin
            r_hold_cnt <= (r_hold_cnt == HOLD_MAX) ? r_hold_cnt : r_hold_cnt + 1'b1;
         end else begin
            r_hold_cnt <= HW'(1);
         end
      end else begin
         r_locked   <= 1'b0;
         r_hold_cnt <= '0;
      end
   end

   assign o_gnt0 = w_gnt0;
   assign o_gnt1 = w_gnt1;
endmodule

// File: rtl/dbus_arbiter.sv
// Two-master arbiter for the shared data bus: grant, bus mux, and routing of
// the one-cycle-latency read data back to the master that issued the read.
module dbus_arbiter
   import dbus_pkg::*;
#(
   parameter int AW      = DBUS_AW,
   parameter int DW      = DBUS_DW,
   parameter int MAXHOLD = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            req0,
   input  logic            req1,
   input  logic            lock0,
   input  logic            lock1,
   input  logic [AW-1:0]   addr0,
   input  logic [AW-1:0]   addr1,
   input  logic [DW/8-1:0] wen0,
   input  logic [DW/8-1:0] wen1,
   input  logic [DW-1:0]   wdata0,
   input  logic [DW-1:0]   wdata1,
   output logic            gnt0,
   output logic            gnt1,
   output logic [DW-1:0]   rdata0,
   output logic [DW-1:0]   rdata1,
   output logic            rvalid0,
   output logic            rvalid1,
   output logic [AW-1:0]   bus_addr,
   output logic [DW/8-1:0] bus_wen,
   output logic [DW-1:0]   bus_wdata,
   input  logic [DW-1:0]   bus_rdata
);
   logic w_gnt0;
   logic w_gnt1;
   logic r_rvalid0;
   logic r_rvalid1;

   dbus_grant_logic #(
      .MAXHOLD (MAXHOLD)
   ) u_grant (
      .i_clk   (clk),
      .i_rst_n (reset),
      .i_req0  (req0),
      .i_req1  (req1),
      .i_lock0 (lock0),
      .i_lock1 (lock1),
      .o_gnt0  (w_gnt0),
      .o_gnt1  (w_gnt1)
   );

   // With no grant the bus idles at zero so the decoder never sees a stray write.
   always_comb begin
      bus_addr  = '0;
      bus_wen   = '0;
      bus_wdata = '0;
      if (w_gnt0) begin
         bus_addr  = addr0;
         bus_wen   = wen0;
         bus_wdata = wdata0;
      end else if (w_gnt1) begin
         bus_addr  = addr1;
         bus_wen   = wen1;
         bus_wdata = wdata1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rvalid0 <= 1'b0;
         r_rvalid1 <= 1'b0;
      end else begin
         r_rvalid0 <= w_gnt0 && is_read(wen0);
         r_rvalid1 <= w_gnt1 && is_read(wen1);
      end
   end

   assign gnt0    = w_gnt0;
   assign gnt1    = w_gnt1;
   assign rvalid0 = r_rvalid0;
   assign rvalid1 = r_rvalid1;
   assign rdata0  = r_rvalid0 ? bus_rdata : '0;
   assign rdata1  = r_rvalid1 ? bus_rdata : '0;
endmodule

// File: tb/tb_dbus_arbiter.sv
// Directed scoreboard bench for dbus_arbiter: stimulus pushes expected grants
// and read responses into queues; a negedge monitor pops and compares them.
module tb_dbus_arbiter;
   import dbus_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        req0, req1, lock0, lock1;
   logic [15:0] addr0, addr1, wdata0, wdata1;
   logic [1:0]  wen0, wen1;
   logic        gnt0, gnt1, rvalid0, rvalid1;
   logic [15:0] rdata0, rdata1;
   logic [15:0] bus_addr, bus_wdata;
   logic [1:0]  bus_wen;
   logic [15:0] bus_rdata = 16'h0;

   typedef struct {
      int        cyc;
      int        id;
      logic      g0;
      logic      g1;
      dbus_req_t bus;
   } gexp_t;

   typedef struct {
      int          cyc;
      int          id;
      logic        v0;
      logic        v1;
      logic [15:0] data;
   } rexp_t;

   gexp_t g_q[$];
   rexp_t r_q[$];
   int    cyc_n   = 0;
   int    step_id = 0;
   int    checks  = 0;
   int    errors  = 0;

   dbus_arbiter #(.AW(16), .DW(16), .MAXHOLD(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .req0      (req0),
      .req1      (req1),
      .lock0     (lock0),
      .lock1     (lock1),
      .addr0     (addr0),
      .addr1     (addr1),
      .wen0      (wen0),
      .wen1      (wen1),
      .wdata0    (wdata0),
      .wdata1    (wdata1),
      .gnt0      (gnt0),
      .gnt1      (gnt1),
      .rdata0    (rdata0),
      .rdata1    (rdata1),
      .rvalid0   (rvalid0),
      .rvalid1   (rvalid1),
      .bus_addr  (bus_addr),
      .bus_wen   (bus_wen),
      .bus_wdata (bus_wdata),
      .bus_rdata (bus_rdata)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] mem_f(input logic [15:0] a);
      return (a == 16'h2000) ? 16'hBEEF : (a ^ 16'hC3A5);
   endfunction

   // Memory behind the decoder: data for last cycle's address.
   always @(posedge clk) begin
      bus_rdata <= mem_f(bus_addr);
      cyc_n     <= cyc_n + 1;
   end

   function automatic dbus_req_t rd(input logic [15:0] a);
      dbus_req_t q;
      q.addr = a; q.wen = 2'b00; q.wdata = 16'h0;
      return q;
   endfunction

   function automatic dbus_req_t wr(input logic [15:0] a, input logic [1:0] w, input logic [15:0] d);
      dbus_req_t q;
      q.addr = a; q.wen = w; q.wdata = d;
      return q;
   endfunction

   function automatic dbus_req_t nil();
      dbus_req_t q;
      q.addr = 16'h0; q.wen = 2'b00; q.wdata = 16'h0;
      return q;
   endfunction

   task automatic step(input logic rst, input logic r0, input logic l0, input dbus_req_t q0,
                       input logic r1, input logic l1, input dbus_req_t q1,
                       input logic e0, input logic e1);
      gexp_t ge_l;
      rexp_t re_l;
      @(posedge clk);
      #1;
      step_id++;
      reset = rst;
      req0 = r0; lock0 = l0; addr0 = q0.addr; wen0 = q0.wen; wdata0 = q0.wdata;
      req1 = r1; lock1 = l1; addr1 = q1.addr; wen1 = q1.wen; wdata1 = q1.wdata;
      if (!rst) r_q.delete();
      ge_l.cyc = cyc_n; ge_l.id = step_id; ge_l.g0 = e0; ge_l.g1 = e1;
      ge_l.bus = e0 ? q0 : (e1 ? q1 : nil());
      g_q.push_back(ge_l);
      if (e0 && q0.wen == 2'b00) begin
         re_l.cyc = cyc_n + 1; re_l.id = step_id; re_l.v0 = 1'b1; re_l.v1 = 1'b0;
         re_l.data = mem_f(q0.addr);
         r_q.push_back(re_l);
      end
      if (e1 && q1.wen == 2'b00) begin
         re_l.cyc = cyc_n + 1; re_l.id = step_id; re_l.v0 = 1'b0; re_l.v1 = 1'b1;
         re_l.data = mem_f(q1.addr);
         r_q.push_back(re_l);
      end
   endtask

   task automatic idle();
      step(1'b1, 1'b0, 1'b0, nil(), 1'b0, 1'b0, nil(), 1'b0, 1'b0);
   endtask

   gexp_t       m_ge;
   rexp_t       m_re;
   logic        m_due;
   logic [15:0] m_rd0, m_rd1;

   always @(negedge clk) begin
      if (g_q.size() > 0 && g_q[0].cyc == cyc_n) begin
         m_ge = g_q.pop_front();
         checks++;
         if ({gnt0, gnt1} !== {m_ge.g0, m_ge.g1}) begin
            errors++;
            $display("FAIL grant step %0d: got gnt0=%b gnt1=%b, want gnt0=%b gnt1=%b",
                     m_ge.id, gnt0, gnt1, m_ge.g0, m_ge.g1);
         end
         checks++;
         if ({bus_addr, bus_wen, bus_wdata} !== m_ge.bus) begin
            errors++;
            $display("FAIL bus step %0d: got addr=%h wen=%b wdata=%h, want addr=%h wen=%b wdata=%h",
                     m_ge.id, bus_addr, bus_wen, bus_wdata, m_ge.bus.addr, m_ge.bus.wen, m_ge.bus.wdata);
         end
         checks++;
         if (((rvalid0 ? 16'h0 : rdata0) !== 16'h0) || ((rvalid1 ? 16'h0 : rdata1) !== 16'h0)) begin
            errors++;
            $display("FAIL rdata_idle step %0d: got rdata0=%h rdata1=%h with rvalid0=%b rvalid1=%b, want 0 when not valid",
                     m_ge.id, rdata0, rdata1, rvalid0, rvalid1);
         end
      end
      m_due = (r_q.size() > 0) && (r_q[0].cyc == cyc_n);
      if (m_due || rvalid0 !== 1'b0 || rvalid1 !== 1'b0) begin
         if (m_due) begin
            m_re = r_q.pop_front();
         end else begin
            m_re.cyc = cyc_n; m_re.id = -1; m_re.v0 = 1'b0; m_re.v1 = 1'b0; m_re.data = 16'h0;
         end
         m_rd0 = m_re.v0 ? m_re.data : 16'h0;
         m_rd1 = m_re.v1 ? m_re.data : 16'h0;
         checks++;
         if ({rvalid0, rvalid1, rdata0, rdata1} !== {m_re.v0, m_re.v1, m_rd0, m_rd1}) begin
            errors++;
            $display("FAIL response (issued step %0d) cycle %0d: got rvalid0=%b rvalid1=%b rdata0=%h rdata1=%h, want %b %b %h %h",
                     m_re.id, cyc_n, rvalid0, rvalid1, rdata0, rdata1, m_re.v0, m_re.v1, m_rd0, m_rd1);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL timeout: bench did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b0;
      req0 = 1'b0; req1 = 1'b0; lock0 = 1'b0; lock1 = 1'b0;
      addr0 = 16'h0; addr1 = 16'h0; wen0 = 2'b00; wen1 = 2'b00; wdata0 = 16'h0; wdata1 = 16'h0;

      // Requests held during reset must not produce grants or bus activity.
      step(1'b0, 1'b1, 1'b0, rd(16'h1111), 1'b1, 1'b0, rd(16'h2222), 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0, rd(16'h1111), 1'b1, 1'b0, rd(16'h2222), 1'b0, 1'b0);

      // First read after release; response 0xBEEF next cycle.
      step(1'b1, 1'b1, 1'b0, rd(16'h2000), 1'b0, 1'b0, nil(), 1'b1, 1'b0);
      idle();
      step(1'b0, 1'b0, 1'b0, nil(), 1'b0, 1'b0, nil(), 1'b0, 1'b0);

      // Round-robin from reset: 0,1,0,1 with back-to-back reads.
      for (int i = 0; i < 4; i++)
         step(1'b1, 1'b1, 1'b0, rd(16'h0010), 1'b1, 1'b0, rd(16'h0020), (i % 2) == 0, (i % 2) == 1);
      idle();

      // Master 1 partial write: no response.
      step(1'b1, 1'b0, 1'b0, nil(), 1'b1, 1'b0, wr(16'h0004, 2'b10, 16'hAB00), 1'b0, 1'b1);
      idle();

      // Master 0 locks against a requesting master 1: 4 grants, 1 yield, back to 0.
      for (int i = 0; i < 6; i++)
         step(1'b1, 1'b1, 1'b1, wr(16'h0100, 2'b11, 16'h1111), 1'b1, 1'b0, rd(16'h0200), i != 4, i == 4);
      idle();

      // Master 1 locked alone for 10 cycles; saturated count yields at once to master 0.
      for (int i = 0; i < 10; i++)
         step(1'b1, 1'b0, 1'b0, nil(), 1'b1, 1'b1, wr(16'h0300, 2'b01, 16'h00CD), 1'b0, 1'b1);
      step(1'b1, 1'b1, 1'b0, rd(16'h0400), 1'b1, 1'b1, wr(16'h0300, 2'b01, 16'h00CD), 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0, rd(16'h0400), 1'b1, 1'b1, wr(16'h0300, 2'b01, 16'h00CD), 1'b0, 1'b1);
      step(1'b1, 1'b1, 1'b0, rd(16'h0400), 1'b1, 1'b1, wr(16'h0300, 2'b01, 16'h00CD), 1'b0, 1'b1);
      idle();

      // Reset right after a master-1 read drops its response; master 0 wins after release.
      step(1'b1, 1'b0, 1'b0, nil(), 1'b1, 1'b0, rd(16'h0500), 1'b0, 1'b1);
      step(1'b0, 1'b1, 1'b0, rd(16'h0600), 1'b1, 1'b0, rd(16'h0500), 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, wr(16'h0600, 2'b11, 16'h7777), 1'b1, 1'b0, rd(16'h0500), 1'b1, 1'b0);
      idle();
      idle();

      @(negedge clk);
      #1;
      checks++;
      if (g_q.size() != 0 || r_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d grant and %0d response entries left, want 0 and 0",
                  g_q.size(), r_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
